// File: rtl/morse_letter_tx.sv
// Morse letter transmitter: one-hot A..Z letter in, timed mark/space key signal out.
// Unit period in clocks is latched at accept; dots are 1 unit, dashes DASH_UNITS units.
module morse_letter_tx #(
    parameter int TW         = 31,
    parameter int DASH_UNITS = 3,
    parameter int LGAP_UNITS = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [25:0]   letter_code,
    input  logic [TW-1:0] Unit_time,
    output logic          Key,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

    typedef enum logic [1:0] {IDLE, MARK, SGAP, LGAP} state_t;

    state_t        state, nxt_state;
    logic [TW-1:0] tick, nxt_tick;
    logic [1:0]    unit, nxt_unit;
    logic [TW-1:0] u_reg;
    logic [3:0]    pat_sr;
    logic [1:0]    rem;
    logic [1:0]    units_now;
    logic          unit_end;
    logic          sym_end;
    logic          code_ok;
    logic          accept;
    logic [6:0]    lut_val;

    // {len[2:0], pat[3:0]}; pattern is MSB-first and left-aligned, 1 = dash
    function automatic logic [6:0] letter_lut(input logic [25:0] c);
        logic [6:0] r;
        r = 7'd0;
        case (c)
            26'd1 << 25: r = {3'd2, 4'b0100}; // A
            26'd1 << 24: r = {3'd4, 4'b1000}; // B
            26'd1 << 23: r = {3'd4, 4'b1010}; // C
            26'd1 << 22: r = {3'd3, 4'b1000}; // D
            26'd1 << 21: r = {3'd1, 4'b0000}; // E
            26'd1 << 20: r = {3'd4, 4'b0010}; // F
            26'd1 << 19: r = {3'd3, 4'b1100}; // G
            26'd1 << 18: r = {3'd4, 4'b0000}; // H
            26'd1 << 17: r = {3'd2, 4'b0000}; // I
            26'd1 << 16: r = {3'd4, 4'b0111}; // J
            26'd1 << 15: r = {3'd3, 4'b1010}; // K
            26'd1 << 14: r = {3'd4, 4'b0100}; // L
            26'd1 << 13: r = {3'd2, 4'b1100}; // M
            26'd1 << 12: r = {3'd2, 4'b1000}; // N
            26'd1 << 11: r = {3'd3, 4'b1110}; // O
            26'd1 << 10: r = {3'd4, 4'b0110}; // P
            26'd1 << 9:  r = {3'd4, 4'b1101}; // Q
            26'd1 << 8:  r = {3'd3, 4'b0100}; // R
            26'd1 << 7:  r = {3'd3, 4'b0000}; // S
            26'd1 << 6:  r = {3'd1, 4'b1000}; // T
            26'd1 << 5:  r = {3'd3, 4'b0010}; // U
            26'd1 << 4:  r = {3'd4, 4'b0001}; // V
            26'd1 << 3:  r = {3'd3, 4'b0110}; // W
            26'd1 << 2:  r = {3'd4, 4'b1001}; // X
            26'd1 << 1:  r = {3'd4, 4'b1011}; // Y
            26'd1 << 0:  r = {3'd4, 4'b1100}; // Z
            default:     r = 7'd0;
        endcase
        return r;
    endfunction

    assign code_ok = $onehot(letter_code);
    assign accept  = (state == IDLE) && Start && code_ok;
    assign lut_val = letter_lut(letter_code);

    always_comb begin
        nxt_state = state;
        nxt_tick  = tick;
        nxt_unit  = unit;
        case (state)
            MARK:    units_now = pat_sr[3] ? 2'(DASH_UNITS) : 2'd1;
            LGAP:    units_now = 2'(LGAP_UNITS);
            default: units_now = 2'd1;
        endcase
        unit_end = (tick == u_reg - TW'(1));
        sym_end  = unit_end && (unit == units_now - 2'd1);
        if (state == IDLE) begin
            if (accept) begin
                nxt_state = MARK;
                nxt_tick  = '0;
                nxt_unit  = '0;
            end
        end else if (sym_end) begin
            nxt_tick = '0;
            nxt_unit = '0;
            case (state)
                MARK:    nxt_state = (rem != 2'd0) ? SGAP : LGAP;
                SGAP:    nxt_state = MARK;
                default: nxt_state = IDLE;
            endcase
        end else if (unit_end) begin
            nxt_tick = '0;
            nxt_unit = unit + 2'd1;
        end else begin
            nxt_tick = tick + TW'(1);
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            tick  <= '0;
            unit  <= '0;
            rem   <= '0;
            Key   <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            state <= nxt_state;
            tick  <= nxt_tick;
            unit  <= nxt_unit;
            Key   <= (nxt_state == MARK);
            Busy  <= (nxt_state != IDLE);
            Done  <= (nxt_state == LGAP) && (nxt_tick == u_reg - TW'(1)) &&
                     (nxt_unit == 2'(LGAP_UNITS - 1));
            Err   <= (state == IDLE) && Start && !code_ok;
            if (accept) begin
                rem <= 2'(lut_val[6:4] - 3'd1);
            end else if (state == SGAP && sym_end) begin
                rem <= rem - 2'd1;
            end
        end
    end

    // Letter data is latched at accept only; it needs no reset
    always_ff @(posedge Clk) begin
        if (accept) begin
            u_reg  <= (Unit_time == '0) ? TW'(1) : Unit_time;
            pat_sr <= lut_val[3:0];
        end else if (state == SGAP && sym_end) begin
            pat_sr <= {pat_sr[2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_morse_letter_tx.sv
// Bench for morse_letter_tx: table of letters with hand-written key waveforms,
// plus hand sequences for errors, back-to-back letters and mid-letter reset.
module tb_morse_letter_tx;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [25:0] letter_code = '0;
    logic [30:0] Unit_time = 31'd1;
    logic        Key, Busy, Done, Err;

    int n_assert = 0;
    int n_fail   = 0;

    morse_letter_tx dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .letter_code(letter_code),
        .Unit_time(Unit_time), .Key(Key), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          bit_idx;
        logic [30:0] ut;
        string       key;
        bit          disturb;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [25:0] oh(input int b);
        logic [25:0] r;
        r = '0;
        r[b] = 1'b1;
        return r;
    endfunction

    task automatic check(input string nm, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, " Key"}, Key, 1'b0);
        check({nm, " Busy"}, Busy, 1'b0);
        check({nm, " Done"}, Done, 1'b0);
    endtask

    // Samples at each negedge after the accept edge; Done expected at the last key position
    task automatic watch(input string nm, input string key, input bit disturb,
                         input bit keep_start, input int ncheck);
        int n;
        n = key.len();
        for (int i = 0; i < ncheck; i++) begin
            @(negedge Clk);
            check($sformatf("%s key[%0d]", nm, i), Key, key[i] == "1");
            check($sformatf("%s busy[%0d]", nm, i), Busy, 1'b1);
            check($sformatf("%s done[%0d]", nm, i), Done, i == n - 1);
            if (disturb) begin
                Start       = (i < n - 1) ? i[0] : 1'b0;
                letter_code = oh(0);
                Unit_time   = 31'd7;
            end else if (!keep_start) begin
                Start = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{"E_u4", 21, 31'd4, "1111000000000000", 1'b0};
        vecs[1] = '{"A_u2", 25, 31'd2, "1100111111000000", 1'b0};
        vecs[2] = '{"Y_u1", 1, 31'd1, "1110101110111000", 1'b0};
        vecs[3] = '{"T_u0", 6, 31'd0, "111000", 1'b0};
        vecs[4] = '{"C_u1", 23, 31'd1, "11101011101000", 1'b0};
        vecs[5] = '{"S_u3", 7, 31'd3, "111000111000111000000000", 1'b0};
        vecs[6] = '{"E_u2_busy_noise", 21, 31'd2, "11000000", 1'b1};

        repeat (3) @(negedge Clk);
        check_idle("reset");
        check("reset Err", Err, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        check_idle("post_reset");
        check("post_reset Err", Err, 1'b0);

        for (int v = 0; v < 7; v++) begin
            @(negedge Clk);
            Start       = 1'b1;
            letter_code = oh(vecs[v].bit_idx);
            Unit_time   = vecs[v].ut;
            watch(vecs[v].name, vecs[v].key, vecs[v].disturb, 1'b0, vecs[v].key.len());
            @(negedge Clk);
            check_idle({vecs[v].name, " after"});
        end

        // Invalid codes: zero and two bits set
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            Start       = 1'b1;
            letter_code = (k == 0) ? '0 : (oh(25) | oh(0));
            @(negedge Clk);
            Start = 1'b0;
            check($sformatf("err%0d pulse", k), Err, 1'b1);
            check($sformatf("err%0d busy", k), Busy, 1'b0);
            check($sformatf("err%0d key", k), Key, 1'b0);
            @(negedge Clk);
            check($sformatf("err%0d clear", k), Err, 1'b0);
            check($sformatf("err%0d idle busy", k), Busy, 1'b0);
        end

        // Start held high: Y, then T accepted in the IDLE cycle right after Done
        @(negedge Clk);
        Start       = 1'b1;
        letter_code = oh(1);
        Unit_time   = 31'd1;
        watch("b2b_Y", "1110101110111000", 1'b0, 1'b1, 16);
        letter_code = oh(6);
        @(negedge Clk);
        check_idle("b2b gap");
        watch("b2b_T", "111000", 1'b0, 1'b0, 6);
        @(negedge Clk);
        check_idle("b2b after");

        // Reset during the letter gap abandons the letter without Done
        @(negedge Clk);
        Start       = 1'b1;
        letter_code = oh(21);
        Unit_time   = 31'd2;
        watch("rst_E", "11000000", 1'b0, 1'b0, 4);
        Reset = 1'b1;
        @(negedge Clk);
        check_idle("rst_mid");
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            check($sformatf("rst_after done[%0d]", i), Done, 1'b0);
            check($sformatf("rst_after busy[%0d]", i), Busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
